fifo_wptr_ctrl: RTL and testbench
=================================

# fifo_wptr_ctrl

Parametrised write-side controller for the dual-clock async FIFO in the UART system. It runs entirely in the write clock domain and takes a read pointer that is already synchronised into that domain. It keeps a binary write pointer and publishes the Gray-coded pointer for the read side. It produces registered full, almost-full and fill-level flags, gates the memory write enable, and records overflow attempts in a sticky flag.

## Interface
- ADDR_WIDTH, 3, memory address bits; DEPTH = 2**ADDR_WIDTH; legal range ≥ 2
- AFULL_MARGIN, 2, W_AFULL asserts when fill level ≥ DEPTH − AFULL_MARGIN; legal range 1..DEPTH−1
- W_CLK  input  1  write clock
- W_RST  input  1  asynchronous, active-low reset
- W_INC  input  1  write request from the producer
- W_OVF_CLR  input  1  clears W_OVF
- wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronised to W_CLK
- W_EN  output  1  memory write strobe, combinational: W_INC & ~W_FULL
- W_ADDR  output  ADDR_WIDTH  memory address, equal to wbin[ADDR_WIDTH-1:0]
- W_PTR  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser
- W_FULL  output  1  registered full flag
- W_AFULL  output  1  registered almost-full flag
- W_LEVEL  output  ADDR_WIDTH+1  registered fill level, range 0..DEPTH
- W_OVF  output  1  sticky overflow flag

## Operation
- Internal state: wbin (binary pointer, ADDR_WIDTH+1 bits). W_PTR, W_FULL, W_AFULL, W_LEVEL and W_OVF are all registers.
- **Accept rule.** A write is accepted when W_INC=1 and W_FULL=0 at a rising edge of W_CLK.
  - wbin_next = wbin + acc, modulo 2**(ADDR_WIDTH+1).
  - W_PTR_next = wbin_next ^ (wbin_next >> 1).
- **Full.** full_next = (W_PTR_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}), where AW = ADDR_WIDTH.
- **Level.** level_next = wbin_next − gray2bin(wq2_rptr), computed modulo 2**(ADDR_WIDTH+1).
- **Almost-full.** afull_next = (level_next ≥ DEPTH − AFULL_MARGIN).
- **Overflow.** W_OVF is set by W_INC=1 while W_FULL=1. It is cleared by W_OVF_CLR. If both happen in the same cycle, set wins.
- **Write while full.** The write is dropped: W_EN=0 and the pointer holds.
- **Pessimism.** Flags are conservative. A read-pointer advance clears W_FULL only on the edge after wq2_rptr changes.
- **Wrap-around.** The pointer wraps naturally. The pointer MSB distinguishes full from empty.
- **Reset.** W_RST asserted at any time, including mid-burst, forces all registers to 0 immediately (asynchronous). In-flight requests are discarded.

## Timing
- Reset values: W_PTR=0, W_ADDR=0, W_FULL=0, W_AFULL=0, W_LEVEL=0, W_OVF=0. W_EN follows W_INC after reset.
- W_ADDR is valid in the same cycle as W_EN. Memory captures data at the edge where the write is accepted, using the pre-increment address.
- Flags update on the same edge as the accepted write, so there is zero-cycle latency after a write. After a write, W_FULL=1 is visible before the next request can be sampled, so a full FIFO can never be overrun.
- Read-side relief has 1-cycle latency in this block, in addition to the upstream 2-flop synchroniser.
- Simultaneous write and read-pointer advance: level_next reflects both. W_FULL stays 0 if the FIFO was at DEPTH−1.
- Release from reset is asynchronous. Downstream synchronisers handle deassertion.

## Structure
- Package fifo_pkg holds:
  - the bin2gray and gray2bin functions (parametrised width);
  - a localparam computing DEPTH from ADDR_WIDTH.
- Sub-module fifo_gray2bin is combinational and parametrised by width. It is instantiated here for wq2_rptr and is reused by the read-side controller.
- Everything else is one flat always block with async reset, plus combinational next-state logic.

## Test plan
All scenarios use ADDR_WIDTH=3 and AFULL_MARGIN=2.
- **Reset:** assert W_RST mid-run → all outputs 0 immediately, W_LEVEL=0.
- **Fill from empty:** wq2_rptr=0, 8 back-to-back writes →
  - W_PTR sequence 1,3,2,6,7,5,4,12;
  - W_ADDR 0..7;
  - W_AFULL=1 after the 6th write;
  - W_FULL=1 and W_LEVEL=8 after the 8th write.
- **Overflow:** a 9th W_INC while full → W_EN=0, W_PTR stays 12, W_OVF=1.
  - Then W_OVF_CLR and W_INC together while still full → W_OVF stays 1.
  - Then W_OVF_CLR alone → W_OVF=0.
- **Relief:** from full, set wq2_rptr=1 (Gray of 1) →
  - W_FULL=0 and W_LEVEL=7 on the next edge;
  - a write that cycle → W_FULL=1 again.
- **Wrap:** 20 writes with wq2_rptr trailing by 4 entries →
  - W_PTR passes through 8 (Gray 12), then wraps through 16→0 (Gray 0);
  - W_LEVEL stays 4–5;
  - W_FULL never asserts.
- **Simultaneous:** at level 7, a write plus a one-entry read advance in the same cycle → W_LEVEL=7, W_FULL=0, W_AFULL=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO pointer controllers.
//   fifo_depth  : number of entries for a given address width
//   bin2gray    : binary -> reflected Gray code
//   gray2bin    : reflected Gray code -> binary
// The code converters work on any width up to 32 bits; callers zero-extend
// the value in and truncate the result back to their own pointer width.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended input keeps the unused upper bits at 0, so the prefix-XOR
  // below yields the right answer for any narrower pointer.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// ---------------------------------------------------------------------------
// fifo_gray2bin
// Combinational Gray -> binary converter for a synchronised FIFO pointer.
// Shared between the write-side and read-side pointer controllers.
//   gray : Gray-coded pointer, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// ---------------------------------------------------------------------------
module fifo_gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it; written as
  // an independent reduction per bit so no combinational chain through bin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wptr_ctrl
// Write-domain pointer and flag controller for the UART dual-clock FIFO.
// Keeps the binary write pointer, publishes the Gray pointer to the read
// side, and derives registered full / almost-full / level flags against the
// read pointer already synchronised into W_CLK.
//   W_CLK      : write clock
//   W_RST      : asynchronous active-low reset
//   W_INC      : producer write request
//   W_OVF_CLR  : clears the sticky overflow flag
//   wq2_rptr   : Gray read pointer, synchronised to W_CLK
//   W_EN       : memory write strobe (W_INC & ~W_FULL)
//   W_ADDR     : memory write address (low bits of binary pointer)
//   W_PTR      : registered Gray write pointer
//   W_FULL     : registered full flag
//   W_AFULL    : registered almost-full flag (level >= DEPTH-AFULL_MARGIN)
//   W_LEVEL    : registered fill level, 0..DEPTH
//   W_OVF      : sticky flag, set by a write attempt while full
// ---------------------------------------------------------------------------
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic                  W_OVF_CLR,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR,
  output logic                  W_FULL,
  output logic                  W_AFULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  W_OVF
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wptr_next;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rptr_full_cmp;
  logic [ADDR_WIDTH:0] level_next;
  logic                acc;
  logic                full_next;
  logic                afull_next;
  logic                ovf_next;

  fifo_gray2bin #(
    .WIDTH (PW)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  always_comb begin
    acc       = W_INC & ~W_FULL;
    wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, acc};
    wptr_next = PW'(bin2gray(32'(wbin_next)));

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted, rest equal.
    rptr_full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    full_next     = (wptr_next == rptr_full_cmp);

    // Modulo subtraction across the extra wrap bit gives 0..DEPTH directly.
    level_next = wbin_next - rbin;
    afull_next = (level_next >= AFULL_THRESH);

    // Set has priority over clear so an attempt in the clear cycle is kept.
    ovf_next = (W_INC & W_FULL) | (W_OVF & ~W_OVF_CLR);
  end

  assign W_EN   = acc;
  assign W_ADDR = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin    <= '0;
      W_PTR   <= '0;
      W_FULL  <= 1'b0;
      W_AFULL <= 1'b0;
      W_LEVEL <= '0;
      W_OVF   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      W_PTR   <= wptr_next;
      W_FULL  <= full_next;
      W_AFULL <= afull_next;
      W_LEVEL <= level_next;
      W_OVF   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
module tb_fifo_wptr_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int MOD   = 2 * DEPTH;

  logic          W_CLK;
  logic          W_RST;
  logic          W_INC;
  logic          W_OVF_CLR;
  logic [AW:0]   wq2_rptr;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [AW:0]   W_PTR;
  logic          W_FULL;
  logic          W_AFULL;
  logic [AW:0]   W_LEVEL;
  logic          W_OVF;

  fifo_wptr_ctrl #(
    .ADDR_WIDTH   (AW),
    .AFULL_MARGIN (AFM)
  ) dut (
    .W_CLK     (W_CLK),
    .W_RST     (W_RST),
    .W_INC     (W_INC),
    .W_OVF_CLR (W_OVF_CLR),
    .wq2_rptr  (wq2_rptr),
    .W_EN      (W_EN),
    .W_ADDR    (W_ADDR),
    .W_PTR     (W_PTR),
    .W_FULL    (W_FULL),
    .W_AFULL   (W_AFULL),
    .W_LEVEL   (W_LEVEL),
    .W_OVF     (W_OVF)
  );

  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: total accepted writes and current read count, unbounded.
  int wcnt    = 0;
  int rcnt    = 0;
  int m_level = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  bit m_ovf   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic step(input bit inc, input bit clr, input int rc);
    bit acc;
    @(negedge W_CLK);
    W_INC     = inc;
    W_OVF_CLR = clr;
    rcnt      = rc;
    wq2_rptr  = 4'(gray(rc % MOD));
    #1;
    chk("w_en", int'(W_EN), int'(inc && !m_full));
    chk("w_addr", int'(W_ADDR), wcnt % DEPTH);
    @(posedge W_CLK);
    acc     = inc && !m_full;
    m_ovf   = (inc && m_full) || (m_ovf && !clr);
    wcnt    = wcnt + int'(acc);
    m_level = (wcnt - rcnt) % MOD;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= DEPTH - AFM);
    #1;
    chk("w_ptr", int'(W_PTR), gray(wcnt % MOD));
    chk("w_full", int'(W_FULL), int'(m_full));
    chk("w_afull", int'(W_AFULL), int'(m_afull));
    chk("w_level", int'(W_LEVEL), m_level);
    chk("w_ovf", int'(W_OVF), int'(m_ovf));
  endtask

  // Reset asserted away from any clock edge while a write is being requested.
  task automatic do_reset();
    @(negedge W_CLK);
    W_INC     = 1'b1;
    W_OVF_CLR = 1'b0;
    #2 W_RST = 1'b0;
    #1;
    chk("rst_ptr", int'(W_PTR), 0);
    chk("rst_addr", int'(W_ADDR), 0);
    chk("rst_full", int'(W_FULL), 0);
    chk("rst_afull", int'(W_AFULL), 0);
    chk("rst_level", int'(W_LEVEL), 0);
    chk("rst_ovf", int'(W_OVF), 0);
    chk("rst_en", int'(W_EN), 1);
    wcnt = 0; rcnt = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
    wq2_rptr = '0;
    @(negedge W_CLK);
    W_INC = 1'b0;
    W_RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ptr[8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    bit seen12, seen0, any_full, lvl_ok;

    W_RST = 1'b0; W_INC = 1'b0; W_OVF_CLR = 1'b0; wq2_rptr = '0;
    #1;
    chk("init_ptr", int'(W_PTR), 0);
    chk("init_level", int'(W_LEVEL), 0);
    chk("init_full", int'(W_FULL), 0);
    chk("init_ovf", int'(W_OVF), 0);
    @(negedge W_CLK);
    W_RST = 1'b1;

    // Fill from empty
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("fill_ptr_seq", int'(W_PTR), exp_ptr[i]);
      if (i == 4) chk("fill_afull_5", int'(W_AFULL), 0);
      if (i == 5) chk("fill_afull_6", int'(W_AFULL), 1);
      if (i == 6) chk("fill_full_7", int'(W_FULL), 0);
    end
    chk("fill_full_8", int'(W_FULL), 1);
    chk("fill_level_8", int'(W_LEVEL), 8);

    // Overflow, clear-while-set, plain clear
    step(1, 0, 0);
    chk("ovf_ptr_hold", int'(W_PTR), 12);
    chk("ovf_set", int'(W_OVF), 1);
    step(1, 1, 0);
    chk("ovf_set_wins", int'(W_OVF), 1);
    step(0, 1, 0);
    chk("ovf_cleared", int'(W_OVF), 0);

    // Relief from full, then refill
    step(0, 0, 1);
    chk("relief_full", int'(W_FULL), 0);
    chk("relief_level", int'(W_LEVEL), 7);
    step(1, 0, 1);
    chk("refill_full", int'(W_FULL), 1);

    do_reset();

    // Wrap with read pointer trailing by 4
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    seen12 = 0; seen0 = 0; any_full = 0; lvl_ok = 1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, wcnt - 4);
      if (W_PTR == 4'd12) seen12 = 1;
      if (W_PTR == 4'd0) seen0 = 1;
      if (W_FULL) any_full = 1;
      if (W_LEVEL < 4 || W_LEVEL > 5) lvl_ok = 0;
    end
    chk("wrap_seen_g12", int'(seen12), 1);
    chk("wrap_seen_g0", int'(seen0), 1);
    chk("wrap_no_full", int'(any_full), 0);
    chk("wrap_level_4_5", int'(lvl_ok), 1);

    // Simultaneous write and read advance at level 7
    step(1, 0, rcnt);
    step(1, 0, rcnt);
    chk("sim_pre_level", int'(W_LEVEL), 7);
    step(1, 0, rcnt + 1);
    chk("sim_level", int'(W_LEVEL), 7);
    chk("sim_full", int'(W_FULL), 0);
    chk("sim_afull", int'(W_AFULL), 1);

    // Randomized traffic with a mid-burst reset
    for (int i = 0; i < 300; i++) begin
      int rc;
      if (i == 150) do_reset();
      rc = rcnt;
      if (rc < wcnt && $urandom_range(0, 9) < 4) rc++;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
